seq_mac_drain: RTL and testbench



---
 rtl/seq_mac_drain.sv | 136 +++++++++++++
 tb/tb_seq_mac_drain.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_mac_drain.sv
// Requantizing drain stage for the sequential MAC array: captures an M x N accumulator
// matrix and streams one rounded, clamped row per cycle. Define SEQ_MAC_DRAIN_RELU_EN for ReLU.
module seq_mac_drain #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  localparam int RW       = (M > 1) ? $clog2(M) : 1,
  localparam int SW       = $clog2(N + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [M*N*IN_WIDTH-1:0]     d_i,
  input  logic [4:0]                  shift_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [N*OUT_WIDTH-1:0]      row_o,
  output logic [RW-1:0]               row_idx_o,
  output logic                        last_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [15:0]                 sat_cnt_o
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;
  localparam logic [RW-1:0]            LAST_ROW = RW'(M - 1);

  state_t                    state_q, state_d;
  logic [RW-1:0]             row_q, row_d;
  logic [M*N*IN_WIDTH-1:0]   buf_q, buf_d;
  logic [4:0]                shift_q, shift_d;
  logic [15:0]               sat_cnt_q, sat_cnt_d;
  logic [N*OUT_WIDTH-1:0]    row_val;
  logic [SW-1:0]             row_sat;
  logic [16:0]               sat_sum;
  logic                      is_last;

  // Returns {clamped_flag, result}; the extra top bit keeps the rounding add from wrapping.
  function automatic logic [OUT_WIDTH:0] requant(input logic [IN_WIDTH-1:0] x, input logic [4:0] s);
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] half;
    logic signed [IN_WIDTH:0] y;
    logic                     sat;
    ext  = signed'({x[IN_WIDTH-1], x});
    half = '0;
    if (s != 5'd0) half = signed'((IN_WIDTH+1)'(1) << (s - 5'd1));
    y = (ext + half) >>> s;
`ifdef SEQ_MAC_DRAIN_RELU_EN
    if (y < 0) y = '0;
`endif
    sat = 1'b0;
    if (y > MAXV) begin
      y   = MAXV;
      sat = 1'b1;
    end else if (y < MINV) begin
      y   = MINV;
      sat = 1'b1;
    end
    return {sat, y[OUT_WIDTH-1:0]};
  endfunction

  always_comb begin
    logic [OUT_WIDTH:0] q;
    int unsigned        base;
    row_val = '0;
    row_sat = '0;
    for (int unsigned c = 0; c < N; c++) begin
      base = (32'(row_q) * N + c) * IN_WIDTH;
      q    = requant(buf_q[base +: IN_WIDTH], shift_q);
      row_val[c*OUT_WIDTH +: OUT_WIDTH] = q[OUT_WIDTH-1:0];
      row_sat = row_sat + SW'(q[OUT_WIDTH]);
    end
  end

  assign is_last   = (state_q == EMIT) && (row_q == LAST_ROW);
  assign valid_o   = (state_q == EMIT);
  assign last_o    = is_last;
  assign ready_o   = (state_q == IDLE) ? 1'b1 : (is_last & ready_i);
  assign row_o     = row_val;
  assign row_idx_o = row_q;
  assign sat_cnt_o = sat_cnt_q;
  assign sat_sum   = {1'b0, sat_cnt_q} + 17'(row_sat);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    buf_d     = buf_q;
    shift_d   = shift_q;
    sat_cnt_d = sat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          buf_d   = d_i;
          shift_d = shift_i;
          row_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (ready_i) begin
          sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
          if (row_q != LAST_ROW) begin
            row_d = row_q + RW'(1);
          end else if (valid_i) begin
            buf_d   = d_i;
            shift_d = shift_i;
            row_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      row_q     <= '0;
      buf_q     <= '0;
      shift_q   <= '0;
      sat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      buf_q     <= buf_d;
      shift_q   <= shift_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_mac_drain.sv
// Directed bench for seq_mac_drain (M=N=2, 32-bit in, 8-bit out); expected rows hand-computed.
module tb_seq_mac_drain;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [127:0] d_i;
  logic [4:0]   shift_i;
  logic         valid_i;
  logic         ready_o;
  logic [15:0]  row_o;
  logic [0:0]   row_idx_o;
  logic         last_o;
  logic         valid_o;
  logic         ready_i;
  logic [15:0]  sat_cnt_o;

  int checks   = 0;
  int failures = 0;

  seq_mac_drain #(.M(2), .N(2), .IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .d_i       (d_i),
    .shift_i   (shift_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .row_o     (row_o),
    .row_idx_o (row_idx_o),
    .last_o    (last_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .sat_cnt_o (sat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [31:0] a00, input logic [31:0] a01,
                       input logic [31:0] a10, input logic [31:0] a11, input logic [4:0] s);
    d_i     = {a11, a10, a01, a00};
    shift_i = s;
    valid_i = 1'b1;
  endtask

  task automatic exp_row(input string tag, input int e0, input int e1, input int idx, input int last);
    check({tag, ".valid"}, int'(valid_o), 1);
    check({tag, ".e0"}, int'($signed(row_o[7:0])), e0);
    check({tag, ".e1"}, int'($signed(row_o[15:8])), e1);
    check({tag, ".idx"}, int'(row_idx_o), idx);
    check({tag, ".last"}, int'(last_o), last);
  endtask

  initial begin
    rst_i   = 1'b1;
    d_i     = '0;
    shift_i = '0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    check("rst.valid", int'(valid_o), 0);
    check("rst.ready", int'(ready_o), 1);
    check("rst.last", int'(last_o), 0);
    check("rst.idx", int'(row_idx_o), 0);
    check("rst.row", int'(row_o), 0);
    check("rst.sat", int'(sat_cnt_o), 0);

`ifdef SEQ_MAC_DRAIN_RELU_EN
    drive(-50, 50, -1, 1000, 0);
    step();
    valid_i = 1'b0;
    exp_row("relu.r0", 0, 50, 0, 0);
    step();
    exp_row("relu.r1", 0, 127, 1, 1);
    step();
    check("relu.idle", int'(valid_o), 0);
    check("relu.sat", int'(sat_cnt_o), 1);
`else
    // basic round-half-up
    drive(100, -100, 3, -3, 2);
    step();
    valid_i = 1'b0;
    exp_row("t1.r0", 25, -25, 0, 0);
    check("t1.r0.ready", int'(ready_o), 0);
    step();
    exp_row("t1.r1", 1, -1, 1, 1);
    check("t1.r1.ready", int'(ready_o), 1);
    step();
    check("t1.idle", int'(valid_o), 0);
    check("t1.idle.ready", int'(ready_o), 1);
    check("t1.sat", int'(sat_cnt_o), 0);

    // saturation, including the non-wrapping rounding add
    drive(32'h7FFF_FFFF, 32'h8000_0000, 200, -200, 1);
    step();
    valid_i = 1'b0;
    exp_row("t2.r0", 127, -128, 0, 0);
    step();
    exp_row("t2.r1", 100, -100, 1, 1);
    step();
    check("t2.idle", int'(valid_o), 0);
    check("t2.sat", int'(sat_cnt_o), 2);

    // back-to-back matrices with no bubble
    drive(100, -100, 3, -3, 2);
    step();
    exp_row("t3.a0", 25, -25, 0, 0);
    drive(8, -8, 16, 0, 3);
    step();
    exp_row("t3.a1", 1, -1, 1, 1);
    check("t3.a1.ready", int'(ready_o), 1);
    step();
    valid_i = 1'b0;
    exp_row("t3.b0", 1, -1, 0, 0);
    step();
    exp_row("t3.b1", 2, 0, 1, 1);
    step();
    check("t3.idle", int'(valid_o), 0);
    check("t3.sat", int'(sat_cnt_o), 2);

    // backpressure on row 0
    drive(1000, -1000, 5, 6, 0);
    ready_i = 1'b0;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_row($sformatf("t4.stall%0d", i), 127, -128, 0, 0);
      check($sformatf("t4.stall%0d.ready", i), int'(ready_o), 0);
      check($sformatf("t4.stall%0d.sat", i), int'(sat_cnt_o), 2);
      step();
    end
    ready_i = 1'b1;
    exp_row("t4.r0", 127, -128, 0, 0);
    step();
    exp_row("t4.r1", 5, 6, 1, 1);
    check("t4.r1.sat", int'(sat_cnt_o), 4);
    step();
    check("t4.idle", int'(valid_o), 0);
    check("t4.sat", int'(sat_cnt_o), 4);

    // asynchronous reset while row 1 is presented
    drive(100, -100, 3, -3, 2);
    step();
    valid_i = 1'b0;
    exp_row("t5.r0", 25, -25, 0, 0);
    step();
    exp_row("t5.r1", 1, -1, 1, 1);
    #2 rst_i = 1'b1;
    #1;
    check("t5.rst.valid", int'(valid_o), 0);
    check("t5.rst.ready", int'(ready_o), 1);
    check("t5.rst.sat", int'(sat_cnt_o), 0);
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5.post%0d.valid", i), int'(valid_o), 0);
      check($sformatf("t5.post%0d.idx", i), int'(row_idx_o), 0);
      check($sformatf("t5.post%0d.ready", i), int'(ready_o), 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
